// File: rtl/enum_walk_pkg.sv
// Shared types for the enum range walker.
// Members, groups, FSM states and walk constants.
package enum_walk_pkg;

   typedef enum logic [3:0] {
      X0 = 4'd0,
      X1 = 4'd1,
      Y  = 4'd2,
      Z0 = 4'd3,
      Z1 = 4'd4,
      Z2 = 4'd5,
      C4 = 4'd6,
      C3 = 4'd7,
      C2 = 4'd8
   } member_t;

   typedef enum logic [1:0] {
      G_X = 2'd0,
      G_Y = 2'd1,
      G_Z = 2'd2,
      G_C = 2'd3
   } group_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } walk_state_t;

   localparam int          MEMBER_COUNT = 9;
   localparam logic [3:0]  LAST_MEMBER  = 4'd8;

endpackage

// File: rtl/enum_member_decode.sv
// Combinational member -> (group, range index) decode.
// Ports: member in; grp, index out.
import enum_walk_pkg::*;

module enum_member_decode (
   input  member_t     member,
   output group_t      grp,
   output logic [2:0]  index
);

   always_comb begin
      grp   = G_X;
      index = '0;
      unique case (1'b1)
         member inside {X0, X1}: begin
            grp   = G_X;
            index = 3'(member);
         end
         member == Y: begin
            grp   = G_Y;
            index = '0;
         end
         member inside {Z0, Z1, Z2}: begin
            grp   = G_Z;
            index = 3'(4'(member) - 4'd3);
         end
         default: begin
            // C4..C2 count down as the encoding rises
            grp   = G_C;
            index = 3'(4'd10 - 4'(member));
         end
      endcase
   end

endmodule

// File: rtl/enum_range_walker.sv
// Walks member_t forward/reverse for a beat count.
// Ports: cmd_* handshake in, out_* beat stream, sticky err.
import enum_walk_pkg::*;

module enum_range_walker #(
   parameter int COUNT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_dir,
   input  logic [3:0]         cmd_start,
   input  logic [COUNT_W-1:0] cmd_count,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_member,
   output logic [1:0]         out_group,
   output logic [2:0]         out_index,
   output logic               out_wrap,
   output logic               out_last,
   output logic               err
);

   // Wide enough for both the user count and the 9-beat default
   localparam int RW = (COUNT_W > 4) ? COUNT_W : 4;

   walk_state_t   state;
   logic [3:0]    mem;
   logic          dir;
   logic [RW-1:0] rem;
   logic          wrap;
   group_t        grp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         mem   <= '0;
         dir   <= 1'b0;
         rem   <= '0;
         wrap  <= 1'b0;
         err   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  dir   <= cmd_dir;
                  wrap  <= 1'b0;
                  state <= S_RUN;
                  if (cmd_count == '0)
                     rem <= RW'(MEMBER_COUNT);
                  else
                     rem <= RW'(cmd_count);
                  if (cmd_start > LAST_MEMBER) begin
                     mem <= '0;
                     err <= 1'b1;
                  end else begin
                     mem <= cmd_start;
                  end
               end
            end
            S_RUN: begin
               if (out_ready) begin
                  if (rem == RW'(1)) begin
                     state <= S_IDLE;
                     wrap  <= 1'b0;
                  end else begin
                     rem <= rem - RW'(1);
                     if (!dir) begin
                        wrap <= (mem == LAST_MEMBER);
                        mem  <= (mem == LAST_MEMBER)
                              ? 4'd0 : mem + 4'd1;
                     end else begin
                        wrap <= (mem == 4'd0);
                        mem  <= (mem == 4'd0)
                              ? LAST_MEMBER : mem - 4'd1;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready  = (state == S_IDLE);
   assign out_valid  = (state == S_RUN);
   assign out_member = mem;
   assign out_wrap   = wrap;
   assign out_last   = (state == S_RUN) && (rem == RW'(1));
   assign out_group  = grp;

   enum_member_decode u_dec (
      .member (member_t'(mem)),
      .grp    (grp),
      .index  (out_index)
   );

endmodule

// File: tb/tb_enum_range_walker.sv
// Self-checking bench for enum_range_walker.
// Directed cases then random commands vs. a table model.
module tb_enum_range_walker;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_dir;
   logic [3:0]    cmd_start;
   logic [CW-1:0] cmd_count;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_member;
   logic [1:0]    out_group;
   logic [2:0]    out_index;
   logic          out_wrap;
   logic          out_last;
   logic          err;

   int checks   = 0;
   int failures = 0;
   bit err_m    = 1'b0;

   int grp_tab [9] = '{0, 0, 1, 2, 2, 2, 3, 3, 3};
   int idx_tab [9] = '{0, 1, 0, 0, 1, 2, 4, 3, 2};

   logic [11:0] obs;
   assign obs = {out_valid, out_member, out_group,
                 out_index, out_wrap, out_last};

   enum_range_walker #(.COUNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_start  (cmd_start),
      .cmd_count  (cmd_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_member (out_member),
      .out_group  (out_group),
      .out_index  (out_index),
      .out_wrap   (out_wrap),
      .out_last   (out_last),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Beat k of a walk of n beats from s0
   function automatic logic [11:0] beat(input bit d,
                                        input int s0,
                                        input int k,
                                        input int n);
      int m;
      bit w;
      if (d)
         m = (((s0 - k) % 9) + 9) % 9;
      else
         m = (s0 + k) % 9;
      w = (k > 0) && (d ? (m == 8) : (m == 0));
      return {1'b1, 4'(m), 2'(grp_tab[m]),
              3'(idx_tab[m]), w, (k == n - 1)};
   endfunction

   task automatic run_cmd(input bit d, input int s,
                          input int c, input int stall0,
                          input int stall_pct);
      int n;
      int s0;
      int t;
      int hold;
      int spin;
      logic [11:0] e;
      n  = (c == 0) ? 9 : c;
      s0 = (s > 8) ? 0 : s;
      cmd_dir   = d;
      cmd_start = 4'(s);
      cmd_count = CW'(c);
      cmd_valid = 1'b1;
      out_ready = 1'b0;
      t = 0;
      while (!cmd_ready && t < 20) begin
         tick();
         t++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      if (s > 8) err_m = 1'b1;
      hold = 0;
      for (int k = 0; k < n; k++) begin
         e = beat(d, s0, k, n);
         spin = 0;
         do begin
            if (k == 0 && hold < stall0) begin
               out_ready = 1'b0;
               hold++;
            end else begin
               out_ready = (spin > 20) ||
                  ($urandom_range(99) >= stall_pct);
            end
            chk("beat", 32'(obs), 32'(e));
            chk("err", 32'(err), 32'(err_m));
            chk("busy", 32'(cmd_ready), 32'd0);
            spin++;
            tick();
         end while (!out_ready);
      end
      out_ready = 1'b0;
      chk("done", 32'({out_valid, cmd_ready}), 32'b01);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_dir   = 1'b0;
      cmd_start = '0;
      cmd_count = '0;
      out_ready = 1'b0;

      tick();
      tick();
      chk("reset", 32'({cmd_ready, out_valid, out_member,
                        out_wrap, out_last, err}),
          32'({1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}));
      rst_n = 1'b1;
      tick();

      // full forward sweep, index pattern from the tables
      run_cmd(1'b0, 0, 0, 0, 0);
      // reverse 1,0,8,7
      run_cmd(1'b1, 1, 4, 0, 0);
      // forward 7,8,0 with 3-cycle stall on first beat
      run_cmd(1'b0, 7, 3, 3, 0);
      // out-of-range start, then err stays through a valid command
      run_cmd(1'b0, 12, 2, 0, 0);
      run_cmd(1'b1, 4, 5, 0, 25);

      // cmd_valid held high through RUN
      cmd_dir   = 1'b0;
      cmd_start = 4'd3;
      cmd_count = CW'(2);
      cmd_valid = 1'b1;
      out_ready = 1'b1;
      chk("hold_ready", 32'(cmd_ready), 32'd1);
      tick();
      chk("hold_b0", 32'(obs), 32'(beat(1'b0, 3, 0, 2)));
      chk("hold_busy0", 32'(cmd_ready), 32'd0);
      tick();
      chk("hold_b1", 32'(obs), 32'(beat(1'b0, 3, 1, 2)));
      chk("hold_busy1", 32'(cmd_ready), 32'd0);
      cmd_dir   = 1'b1;
      cmd_start = 4'd5;
      cmd_count = CW'(1);
      tick();
      chk("hold_idle", 32'({out_valid, cmd_ready}), 32'b01);
      tick();
      cmd_valid = 1'b0;
      chk("hold_2nd", 32'(obs), 32'(beat(1'b1, 5, 0, 1)));
      tick();
      chk("hold_end", 32'({out_valid, cmd_ready}), 32'b01);

      // reset mid-sweep on beat 3
      cmd_dir   = 1'b0;
      cmd_start = 4'd0;
      cmd_count = '0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("pre_rst", 32'(obs), 32'(beat(1'b0, 0, 2, 9)));
      rst_n = 1'b0;
      tick();
      err_m = 1'b0;
      chk("mid_rst", 32'({cmd_ready, out_valid, out_member,
                          out_wrap, out_last, err}),
          32'({1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}));
      rst_n = 1'b1;
      out_ready = 1'b0;
      tick();
      chk("post_rst", 32'({out_valid, cmd_ready}), 32'b01);

      // random commands, counts above 9 wrap repeatedly
      for (int i = 0; i < 30; i++) begin
         run_cmd(1'($urandom_range(1)),
                 int'($urandom_range(15)),
                 int'($urandom_range(15)),
                 int'($urandom_range(2)), 30);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
